fpga_clk_mngr_ctrl: RTL
=======================

# fpga_clk_mngr_ctrl

Sequencer for the FPGA slow-clock MMCM (Xilinx clocking wizard) on the free-running board reference clock. It pulses the MMCM reset, waits for lock with a timeout, requires a stable lock window, and only then releases the downstream slow-clock-domain reset. Lock loss re-sequences the MMCM. After repeated lock failures it parks in a FAIL state that only a restart request or reset can clear. It sits beside the slow clock generator in the FPGA top level.

## Interface
- `RST_CYCLES`, 16: MMCM reset pulse width in `ref_clk_i` cycles (≥1).
- `LOCK_TIMEOUT`, 65535: maximum cycles in WAIT_LOCK before a retry (≥3).
- `STABLE_CYCLES`, 1024: consecutive locked cycles required before RUN (≥1).
- `MAX_RETRIES`, 3: timeout retries allowed before FAIL.
- `ref_clk_i`  in  1: free-running reference clock, the only clock.
- `rst_i`  in  1: reset, synchronous, active-high.
- `mmcm_locked_i`  in  1: MMCM `locked`, asynchronous; a 2-flop synchronizer inside gives `locked_s`.
- `restart_i`  in  1: level, sampled each cycle; high forces a fresh sequence.
- `mmcm_rst_o`  out  1: active-high MMCM reset. The top level drives the wizard `resetn` with its inverse.
- `slow_rst_no`  out  1: active-low reset request for the slow-clock domain. The consumer resynchronizes it.
- `clk_ok_o`  out  1: slow clock locked and stable.
- `fail_o`  out  1: retries exhausted.
- `retry_cnt_o`  out  $clog2(MAX_RETRIES+1): timeouts since the last RUN or restart.
- `state_o`  out  3: encoding RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

## Operation
States:
- **RESET**
  - `mmcm_rst_o`=1; the cycle counter counts up.
  - After RST_CYCLES cycles in this state: go to WAIT_LOCK, counter cleared.
- **WAIT_LOCK**
  - `mmcm_rst_o`=0; the counter counts cycles in this state.
  - `locked_s` is ignored for the first 2 cycles (synchronizer flush of stale lock).
  - From the 3rd cycle on, `locked_s`=1: go to STABLE, counter cleared.
  - Counter reaches LOCK_TIMEOUT without lock:
    - if `retry_cnt` < MAX_RETRIES: `retry_cnt`+1, go to RESET.
    - otherwise: go to FAIL.
- **STABLE**
  - Counter increments while `locked_s`=1.
  - `locked_s`=0: go to WAIT_LOCK, counter cleared. The 2-cycle blank does not apply here. `retry_cnt` is unchanged.
  - Counter reaches STABLE_CYCLES: go to RUN and clear `retry_cnt`.
- **RUN**
  - `clk_ok_o`=1, `slow_rst_no`=1.
  - `locked_s`=0: go to RESET with `retry_cnt` unchanged (0).
- **FAIL**
  - `mmcm_rst_o`=1, `fail_o`=1, `slow_rst_no`=0.
  - Stays here until `restart_i` or `rst_i`.

Priority per cycle: `rst_i` > `restart_i` > lock/timeout events.
- `restart_i`=1 in any state: next state RESET, `retry_cnt`=0, counter cleared.
- Held `restart_i` keeps the block in RESET.

Outputs:
- Every output is a dedicated flop loaded from the next-state decode. Outputs are Moore, glitch-free, and change on the same edge as `state_o`.
- `slow_rst_no`=0 and `clk_ok_o`=0 in every state except RUN.
- Counter width is $clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1). It saturates and never wraps.

## Timing
- Values while `rst_i`=1 and on the first edge after:
  - state RESET, `mmcm_rst_o`=1, `slow_rst_no`=0, `clk_ok_o`=0, `fail_o`=0.
  - `retry_cnt_o`=0, counter 0, synchronizer flops 0.
- Define edge 1 as the first rising edge with `rst_i`=0.
  - `mmcm_rst_o` stays high through edge RST_CYCLES-1.
  - It falls on edge RST_CYCLES, when `state_o`=1.
- `mmcm_locked_i` to `locked_s` latency is 2 cycles. WAIT_LOCK→STABLE happens 1 edge after `locked_s` is seen (earliest: the 3rd cycle in WAIT_LOCK).
- STABLE→RUN: on the STABLE_CYCLES-th consecutive locked edge in STABLE.
- Loss of lock in RUN: `clk_ok_o` and `slow_rst_no` drop and `mmcm_rst_o` rises 3 edges after `mmcm_locked_i` falls (2 sync + 1 state).
- Timeout: exactly LOCK_TIMEOUT cycles in WAIT_LOCK, then RESET or FAIL on the next edge.
- `rst_i` mid-sequence, in any state: RESET values on the next edge. Counters and `retry_cnt` are cleared.

## Test plan
- **Nominal:** RST_CYCLES=4, STABLE_CYCLES=8. Raise `mmcm_locked_i` 10 cycles after `mmcm_rst_o` falls → `state_o` goes 0→1→2→3. `clk_ok_o`=`slow_rst_no`=1 exactly 2+1+8 edges after `locked_i` rises. `retry_cnt_o`=0.
- **Timeout to FAIL:** LOCK_TIMEOUT=100, MAX_RETRIES=2, lock never asserted → two RESET pulses of 4 cycles each with `retry_cnt_o`=1 then 2. After the 3rd timeout: `fail_o`=1, `mmcm_rst_o`=1, state 4, held indefinitely.
- **Lock glitch in STABLE:** drop lock for 1 cycle after 5 stable cycles → state returns to 1, `clk_ok_o` stays 0, `retry_cnt_o` unchanged. Relocking then needs a full 8 stable cycles.
- **Lock loss in RUN:** deassert lock in RUN → 3 edges later state 0, `slow_rst_no`=0, `mmcm_rst_o`=1 for 4 cycles. The sequence then repeats to RUN.
- **Restart from FAIL:** pulse `restart_i` for 1 cycle while in FAIL → state 0, `fail_o`=0, `retry_cnt_o`=0. Nominal lock then reaches RUN.
- **Reset mid-STABLE plus stale lock:** `mmcm_locked_i` is held 1 throughout; assert `rst_i` mid-STABLE → RESET values next edge. After RESET completes, the state stays in 1 for 2 cycles before entering STABLE.

Source files
------------

// File: rtl/fpga_clk_mngr_ctrl.sv
// Slow-clock MMCM sequencer: resets the MMCM, waits for lock with timeout/retry,
// qualifies a stable lock window and only then releases the slow-domain reset.
module fpga_clk_mngr_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                               ref_clk_i,
    input  logic                               rst_i,
    input  logic                               mmcm_locked_i,
    input  logic                               restart_i,
    output logic                               mmcm_rst_o,
    output logic                               slow_rst_no,
    output logic                               clk_ok_o,
    output logic                               fail_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt_o,
    output logic [2:0]                         state_o
);

    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_TOP = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW      = $clog2(CNT_TOP + 1);
    localparam int RW      = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_SAT      = {CW{1'b1}};
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END    = CW'(2);
    localparam logic [RW-1:0] RETRY_ZERO   = {RW{1'b0}};
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t         state_r, state_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [RW-1:0]  retry_r, retry_s;
    logic           blank_r, blank_s;
    logic           sync1_r, locked_sync_r;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_SAT) ? v : v + CW'(1);
    endfunction

    // Next-state, counter and retry decode; restart_i overrides every state.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        retry_s = retry_r;
        blank_s = blank_r;
        if (restart_i) begin
            state_s = ST_RESET;
            cnt_s   = CNT_ZERO;
            retry_s = RETRY_ZERO;
        end else begin
            case (state_r)
                ST_RESET: begin
                    if (cnt_r == RST_LAST) begin
                        state_s = ST_WAIT_LOCK;
                        cnt_s   = CNT_ZERO;
                        blank_s = 1'b1;
                    end else begin
                        cnt_s = sat_inc(cnt_r);
                    end
                end
                ST_WAIT_LOCK: begin
                    // Blanking only after an MMCM reset: the synchronizer may still hold a stale lock.
                    if (locked_sync_r && (!blank_r || cnt_r >= BLANK_END)) begin
                        state_s = ST_STABLE;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        cnt_s = CNT_ZERO;
                        if (retry_r < RETRY_MAX) begin
                            retry_s = retry_r + RW'(1);
                            state_s = ST_RESET;
                        end else begin
                            state_s = ST_FAIL;
                        end
                    end else begin
                        cnt_s = sat_inc(cnt_r);
                    end
                end
                ST_STABLE: begin
                    if (!locked_sync_r) begin
                        state_s = ST_WAIT_LOCK;
                        cnt_s   = CNT_ZERO;
                        blank_s = 1'b0;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_s = ST_RUN;
                        cnt_s   = CNT_ZERO;
                        retry_s = RETRY_ZERO;
                    end else begin
                        cnt_s = sat_inc(cnt_r);
                    end
                end
                ST_RUN: begin
                    cnt_s = CNT_ZERO;
                    if (!locked_sync_r) begin
                        state_s = ST_RESET;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_FAIL;
                end
                default: begin
                    state_s = ST_RESET;
                    cnt_s   = CNT_ZERO;
                    retry_s = RETRY_ZERO;
                end
            endcase
        end
    end

    // State, synchronizer and Moore output flops loaded from the next-state decode.
    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            sync1_r       <= 1'b0;
            locked_sync_r <= 1'b0;
            state_r       <= ST_RESET;
            cnt_r         <= CNT_ZERO;
            retry_r       <= RETRY_ZERO;
            blank_r       <= 1'b1;
            mmcm_rst_o    <= 1'b1;
            slow_rst_no   <= 1'b0;
            clk_ok_o      <= 1'b0;
            fail_o        <= 1'b0;
            retry_cnt_o   <= RETRY_ZERO;
            state_o       <= ST_RESET;
        end else begin
            sync1_r       <= mmcm_locked_i;
            locked_sync_r <= sync1_r;
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            retry_r       <= retry_s;
            blank_r       <= blank_s;
            mmcm_rst_o    <= (state_s == ST_RESET) || (state_s == ST_FAIL);
            slow_rst_no   <= (state_s == ST_RUN);
            clk_ok_o      <= (state_s == ST_RUN);
            fail_o        <= (state_s == ST_FAIL);
            retry_cnt_o   <= retry_s;
            state_o       <= state_s;
        end
    end

endmodule
